ltd8253_rd: RTL and testbench
=============================

LTD8253_RD -- requirements
Module: ltd8253_rd

Interface
REQ-001 The block SHALL have parameter NCNT, default 3, meaning the number of counters served; only 3 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port adr, input, 2 bits: 0..2 select counter 0..2, 3 selects the control word.
REQ-005 The block SHALL have port din, input, 8 bits: CPU write data, snooped on control-word writes.
REQ-006 The block SHALL have port wr, input, 1 bit: CPU write strobe, level, acted on at its rising edge.
REQ-007 The block SHALL have port rd, input, 1 bit: CPU read strobe, level, acted on at its rising edge.
REQ-008 The block SHALL have ports cnt0, cnt1, cnt2, input, 16 bits each: live counter values from the timer core.
REQ-009 The block SHALL have port dout, output, 8 bits: registered read data.
REQ-010 The block SHALL have port dout_oe, output, 1 bit: read-data valid/drive enable.

Function
REQ-011 wr and rd edges SHALL be detected by comparing each strobe with its value registered on the previous clk.
REQ-012 A control word (wr edge, adr=3) SHALL decode as SC=din[7:6], RL=din[5:4]; din[3:0] are ignored.
REQ-013 On a control word with SC=n (n<3) and RL≠00: rl[n]<=RL, latched[n]<=0, byte pointer ptr[n]<=0.
REQ-014 On a latch command (SC=n<3, RL=00) with latched[n]=0: lat[n]<=cnt_n and latched[n]<=1; when latched[n]=1 the command SHALL be ignored.
REQ-015 Writes with adr 0..2 SHALL NOT change any state.
REQ-016 On an rd edge with adr=n<3, the source SHALL be lat[n] when latched[n]=1, else the live cnt_n sampled that cycle.
REQ-017 When rl[n]=01, dout<=source[7:0]; when rl[n]=10, dout<=source[15:8]; in both cases latched[n]<=0.
REQ-018 When rl[n]=11 and ptr[n]=0: dout<=source[7:0] and ptr<=1; when ptr[n]=1: dout<=source[15:8], ptr<=0 and latched[n]<=0.
REQ-019 An rd edge with adr=3 SHALL give dout<=8'hFF with no state change.
REQ-020 dout SHALL update in the cycle after the rd edge clock; dout_oe SHALL be rd registered once, so the latency is 1 clk.
REQ-021 dout SHALL hold its value between reads.
REQ-022 When a wr edge and an rd edge occur in the same cycle, the write SHALL be processed and the read ignored, leaving dout and ptr unchanged.
REQ-023 Unlatched RL=11 reads SHALL sample the live value per byte; tearing between bytes is permitted.

Reset
REQ-024 While rst=1 the block SHALL set rl[*]=11, ptr[*]=0, latched[*]=0, lat[*]=0, dout=0, dout_oe=0 and the strobe history registers to 0.
REQ-025 An assertion of rst mid-sequence SHALL abandon any pending MSB byte and any held latch.

Configuration
REQ-026 With PIT_READBACK_EN defined, a control word with SC=11 SHALL be a read-back command: when din[5]=0 (COUNT_n), each counter i selected by din[1+i]=1 with latched[i]=0 SHALL latch as in REQ-014, and din[4] (status) SHALL be ignored.
REQ-027 Without PIT_READBACK_EN, a control word with SC=11 SHALL be ignored.

Structure
REQ-028 The shared package pit_pkg SHALL hold the RL encodings (LATCH=00, LSB=01, MSB=10, BOTH=11), ADR_CTRL=3 and the control-word field bit positions.
REQ-029 Per-counter state (rl, ptr, latched, lat) SHALL live in the sub-module pit_rd_chan, instantiated NCNT times; the top level holds edge detection, decode, the output mux and dout/dout_oe.

Verification
REQ-030 Scenario: after reset, cnt0=16'h1234, rd edge at adr=0 twice -> dout=8'h34, then 8'h12.
REQ-031 Scenario: control 8'h40, latch ctr1 at cnt1=16'hABCD, cnt1 changed to 16'h0001, two reads of adr=1 -> 8'hCD, 8'hAB; a third read -> live 8'h01.
REQ-032 Scenario: latch ctr2 at 16'h5555, second latch at 16'h7777 before reading -> reads return 8'h55, 8'h55.
REQ-033 Scenario: control 8'h10 (ctr0, RL=01), cnt0=16'hBEEF, two reads -> 8'hEF, 8'hEF; control 8'h20 (RL=10), read -> 8'hBE.
REQ-034 Scenario: RL=11 read LSB, then rst pulse, then read -> LSB again; simultaneous wr(adr=3, 8'h00)/rd edge -> dout unchanged, ctr0 latched.
REQ-035 Scenario: with PIT_READBACK_EN, control 8'hCE with cnt0..2=1,2,3 -> each counter returns its latched value; without PIT_READBACK_EN, the same write -> live values.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared encodings for the 8253 read-back path: RL field codes, the control
// address, and bit positions of the control-word fields.
package pit_pkg;

  typedef enum logic [1:0] {
    RL_LATCH = 2'b00,
    RL_LSB   = 2'b01,
    RL_MSB   = 2'b10,
    RL_BOTH  = 2'b11
  } rl_e;

  localparam logic [1:0] ADR_CTRL    = 2'd3;
  localparam logic [1:0] SC_READBACK = 2'b11;

  localparam int CW_SC_HI      = 7;
  localparam int CW_SC_LO      = 6;
  localparam int CW_RL_HI      = 5;
  localparam int CW_RL_LO      = 4;
  localparam int CW_RB_COUNT_N = 5;
  localparam int CW_RB_SEL_LO  = 1;

endpackage

// File: rtl/pit_rd_chan.sv
// Per-counter read state: access mode, byte pointer, and the count latch.
// Presents the byte a read would return this cycle on rd_byte.
module pit_rd_chan
  import pit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_set,
  input  rl_e         ctrl_rl,
  input  logic        latch_req,
  input  logic        rd_req,
  input  logic [15:0] cnt,
  output logic [7:0]  rd_byte
);

  rl_e         rl_q, rl_d;
  logic        ptr_q, ptr_d;
  logic        latched_q, latched_d;
  logic [15:0] lat_q, lat_d;
  logic [15:0] src;

  always_comb begin
    src     = latched_q ? lat_q : cnt;
    rd_byte = src[7:0];
    case (rl_q)
      RL_MSB:  rd_byte = src[15:8];
      RL_BOTH: rd_byte = ptr_q ? src[15:8] : src[7:0];
      default: rd_byte = src[7:0];
    endcase
  end

  always_comb begin
    rl_d      = rl_q;
    ptr_d     = ptr_q;
    latched_d = latched_q;
    lat_d     = lat_q;
    if (ctrl_set) begin
      rl_d      = ctrl_rl;
      latched_d = 1'b0;
      ptr_d     = 1'b0;
    end else if (latch_req && !latched_q) begin
      // A second latch before the first is read keeps the original value.
      lat_d     = cnt;
      latched_d = 1'b1;
    end else if (rd_req) begin
      case (rl_q)
        RL_BOTH: begin
          if (ptr_q) begin
            ptr_d     = 1'b0;
            latched_d = 1'b0;
          end else begin
            ptr_d = 1'b1;
          end
        end
        default: latched_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rl_q      <= RL_BOTH;
      ptr_q     <= 1'b0;
      latched_q <= 1'b0;
      lat_q     <= '0;
    end else begin
      rl_q      <= rl_d;
      ptr_q     <= ptr_d;
      latched_q <= latched_d;
      lat_q     <= lat_d;
    end
  end

endmodule

// File: rtl/ltd8253_rd.sv
// 8253 counter read path: strobe edge detection, control-word snoop, and
// registered read data. Define PIT_READBACK_EN to accept SC=11 read-back.
module ltd8253_rd
  import pit_pkg::*;
#(
  parameter int NCNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  adr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  input  logic [15:0] cnt0,
  input  logic [15:0] cnt1,
  input  logic [15:0] cnt2,
  output logic [7:0]  dout,
  output logic        dout_oe
);

  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_edge, rd_edge, ctrl_wr, rd_take;
  logic [1:0]  sc;
  rl_e         rl;
  logic [15:0] cnt_a   [3];
  logic [7:0]  rd_byte [NCNT];
  logic [NCNT-1:0] rb_latch;
  logic        unused_din;

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = cnt2;

  assign wr_d    = wr;
  assign rd_d    = rd;
  assign wr_edge = wr & ~wr_q;
  assign rd_edge = rd & ~rd_q;
  assign ctrl_wr = wr_edge && (adr == ADR_CTRL);
  // A write edge wins over a coincident read edge.
  assign rd_take = rd_edge && !wr_edge;
  assign sc      = din[CW_SC_HI:CW_SC_LO];
  assign rl      = rl_e'(din[CW_RL_HI:CW_RL_LO]);
  assign unused_din = ^din[4:0];

  for (genvar i = 0; i < NCNT; i++) begin : g_chan
`ifdef PIT_READBACK_EN
    assign rb_latch[i] = (sc == SC_READBACK) && !din[CW_RB_COUNT_N] &&
                         din[CW_RB_SEL_LO+i];
`else
    assign rb_latch[i] = 1'b0;
`endif

    pit_rd_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .ctrl_set  (ctrl_wr && (sc == 2'(i)) && (rl != RL_LATCH)),
      .ctrl_rl   (rl),
      .latch_req (ctrl_wr && (((sc == 2'(i)) && (rl == RL_LATCH)) || rb_latch[i])),
      .rd_req    (rd_take && (adr == 2'(i))),
      .cnt       (cnt_a[i]),
      .rd_byte   (rd_byte[i])
    );
  end

  always_comb begin
    dout_d = dout_q;
    if (rd_take) begin
      if (adr == ADR_CTRL) dout_d = 8'hFF;
      else                 dout_d = rd_byte[adr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign dout_oe = rd_q;

endmodule

// File: tb/tb_ltd8253_rd.sv
// Scoreboard bench for ltd8253_rd: a transaction-level model predicts each
// read byte, a monitor compares on every dout_oe rising edge.
module tb_ltd8253_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = 2'd0;
  logic [7:0]  din = 8'h00;
  logic        wr  = 1'b0;
  logic        rd  = 1'b0;
  logic [15:0] cnt_v [3];
  logic [7:0]  dout;
  logic        dout_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];

  // Reference model state
  logic [1:0]  m_rl      [3];
  logic        m_ptr     [3];
  logic        m_latched [3];
  logic [15:0] m_lat     [3];
  logic [7:0]  m_dout;

  always #5 clk = ~clk;

  ltd8253_rd #(.NCNT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .adr     (adr),
    .din     (din),
    .wr      (wr),
    .rd      (rd),
    .cnt0    (cnt_v[0]),
    .cnt1    (cnt_v[1]),
    .cnt2    (cnt_v[2]),
    .dout    (dout),
    .dout_oe (dout_oe)
  );

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_rl[i] = 2'b11; m_ptr[i] = 1'b0; m_latched[i] = 1'b0; m_lat[i] = 16'h0;
    end
    m_dout = 8'h00;
  endtask

  task automatic m_latch(input int n);
    if (!m_latched[n]) begin
      m_lat[n] = cnt_v[n];
      m_latched[n] = 1'b1;
    end
  endtask

  task automatic m_write(input logic [1:0] a, input logic [7:0] d);
    int sc;
    sc = int'(d[7:6]);
    if (a != 2'd3) return;
    if (sc < 3) begin
      if (d[5:4] != 2'b00) begin
        m_rl[sc] = d[5:4]; m_latched[sc] = 1'b0; m_ptr[sc] = 1'b0;
      end else begin
        m_latch(sc);
      end
    end else begin
`ifdef PIT_READBACK_EN
      if (!d[5])
        for (int i = 0; i < 3; i++) if (d[1+i]) m_latch(i);
`endif
    end
  endtask

  task automatic m_read(input logic [1:0] a);
    logic [15:0] src;
    logic hi;
    if (a == 2'd3) begin
      m_dout = 8'hFF;
      return;
    end
    src = m_latched[a] ? m_lat[a] : cnt_v[a];
    hi  = (m_rl[a] == 2'b10) || (m_rl[a] == 2'b11 && m_ptr[a]);
    m_dout = hi ? src[15:8] : src[7:0];
    if (m_rl[a] == 2'b11 && !m_ptr[a]) m_ptr[a] = 1'b1;
    else begin
      m_ptr[a] = 1'b0;
      m_latched[a] = 1'b0;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    adr = a; din = d; wr = 1'b1;
    m_write(a, d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a);
    @(negedge clk);
    adr = a; rd = 1'b1;
    m_read(a);
    exp_q.push_back(m_dout);
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Directed read with a hand-derived expectation; model kept in step.
  task automatic do_read_exp(input logic [1:0] a, input logic [7:0] e);
    @(negedge clk);
    adr = a; rd = 1'b1;
    m_read(a);
    exp_q.push_back(e);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_both(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    adr = a; din = d; wr = 1'b1; rd = 1'b1;
    m_write(a, d);
    exp_q.push_back(m_dout);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    checks++;
    if (dout !== 8'h00 || dout_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h oe=%b, required dout=00 oe=0", dout, dout_oe);
    end
  endtask

  // Monitor: compare each presented read byte against the scoreboard.
  logic prev_oe = 1'b0;
  always @(posedge clk) begin
    #1;
    if (dout_oe && !prev_oe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: dout=%h with empty scoreboard", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL read_data: dout=%h, required %h", dout, e);
        end
      end
    end
    prev_oe = dout_oe;
  end

  initial begin
    cnt_v[0] = 16'h0; cnt_v[1] = 16'h0; cnt_v[2] = 16'h0;
    m_reset();
    do_reset();

    // Two-byte live read
    cnt_v[0] = 16'h1234;
    do_read_exp(2'd0, 8'h34);
    do_read_exp(2'd0, 8'h12);

    // Latch survives a change of the live count
    cnt_v[1] = 16'hABCD;
    do_write(2'd3, 8'h40);
    cnt_v[1] = 16'h0001;
    do_read_exp(2'd1, 8'hCD);
    do_read_exp(2'd1, 8'hAB);
    do_read_exp(2'd1, 8'h01);

    // Second latch while holding is ignored
    cnt_v[2] = 16'h5555;
    do_write(2'd3, 8'h80);
    cnt_v[2] = 16'h7777;
    do_write(2'd3, 8'h80);
    do_read_exp(2'd2, 8'h55);
    do_read_exp(2'd2, 8'h55);

    // LSB-only and MSB-only modes
    do_write(2'd3, 8'h10);
    cnt_v[0] = 16'hBEEF;
    do_read_exp(2'd0, 8'hEF);
    do_read_exp(2'd0, 8'hEF);
    do_write(2'd3, 8'h20);
    do_read_exp(2'd0, 8'hBE);
    do_read_exp(2'd3, 8'hFF);

    // Reset abandons pending MSB; write wins over coincident read
    do_write(2'd3, 8'h30);
    cnt_v[0] = 16'hCAFE;
    do_read_exp(2'd0, 8'hFE);
    do_reset();
    do_read_exp(2'd0, 8'hFE);
    do_both(2'd3, 8'h00);
    cnt_v[0] = 16'h1357;
    do_read_exp(2'd0, 8'hCA);

    // Read-back command
    do_reset();
    cnt_v[0] = 16'h0001; cnt_v[1] = 16'h0002; cnt_v[2] = 16'h0003;
    do_write(2'd3, 8'hCE);
    cnt_v[0] = 16'h0A0B; cnt_v[1] = 16'h0C0D; cnt_v[2] = 16'h0E0F;
`ifdef PIT_READBACK_EN
    do_read_exp(2'd0, 8'h01); do_read_exp(2'd0, 8'h00);
    do_read_exp(2'd1, 8'h02); do_read_exp(2'd1, 8'h00);
    do_read_exp(2'd2, 8'h03); do_read_exp(2'd2, 8'h00);
`else
    do_read_exp(2'd0, 8'h0B); do_read_exp(2'd0, 8'h0A);
    do_read_exp(2'd1, 8'h0D); do_read_exp(2'd1, 8'h0C);
    do_read_exp(2'd2, 8'h0F); do_read_exp(2'd2, 8'h0E);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 30)       do_read(2'($urandom_range(0, 3)));
      else if (op < 55)  do_write(2'd3, 8'($urandom));
      else if (op < 62)  do_write(2'($urandom_range(0, 2)), 8'($urandom));
      else if (op < 70)  do_both(2'($urandom_range(0, 3)), 8'($urandom));
      else if (op < 72)  do_reset();
      else begin
        int c;
        c = int'($urandom_range(0, 2));
        cnt_v[c] = 16'($urandom);
        @(negedge clk);
      end
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads never presented, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
